// File: rtl/md_lr_seqr.sv
// md_lr_seqr: timestep sequencer for the MD long-range (PME) engine.
//
// Each timestep walks INIT -> WAIT -> PGMAP -> FFTX -> FFTY -> FFTZNG ->
// IFFTX -> IFFTY -> IFFTZ -> FCALC and then returns to INIT. In INIT the
// sequencer clears grid memory itself. In every later stage it issues one
// start pulse to the owning unit and waits for that unit's done pulse.
//
//   state  | meaning
//   INIT   | clear grid memory, one word per cycle
//   WAIT   | idle, waiting for the first particle beat
//   PGMAP  | particle-to-grid mapping
//   FFTX   | forward FFT along X
//   FFTY   | forward FFT along Y
//   FFTZNG | forward FFT along Z with Green's function applied
//   IFFTX  | inverse FFT along X
//   IFFTY  | inverse FFT along Y
//   IFFTZ  | inverse FFT along Z
//   FCALC  | force calculation and transmission
//   RSVDSA..RSVDSF | illegal encodings, recovered through INIT
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   soft_rst_i              synchronous abort back to INIT
//   part_valid_i            particle beat valid, starts a timestep from WAIT
//   pgmap_start_o/done_i    mapper handshake
//   fft_start_o/done_i      shared 1D FFT engine handshake
//   fft_axis_o, fft_inv_o   FFT axis and direction, stable for the stage
//   green_en_o              Green's function enable (FFTZNG only)
//   fcalc_start_o/done_i    force calculator handshake
//   gm_clr_we_o/addr_o      grid-memory clear port (write data is zero)
//   state_o, busy_o         current state, busy outside WAIT
//   iter_cnt_o              completed timesteps, wrapping
//   err_o                   sticky illegal-state flag

module md_lr_seqr #(
    parameter int GRID_WORDS = 512,
    parameter int GM_AW      = 9,
    parameter int ITER_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_rst_i,
    input  logic              part_valid_i,
    output logic              pgmap_start_o,
    input  logic              pgmap_done_i,
    output logic              fft_start_o,
    output logic [1:0]        fft_axis_o,
    output logic              fft_inv_o,
    output logic              green_en_o,
    input  logic              fft_done_i,
    output logic              fcalc_start_o,
    input  logic              fcalc_done_i,
    output logic              gm_clr_we_o,
    output logic [GM_AW-1:0]  gm_clr_addr_o,
    output logic [3:0]        state_o,
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic              err_o
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        WAIT   = 4'd1,
        PGMAP  = 4'd2,
        FFTX   = 4'd3,
        FFTY   = 4'd4,
        FFTZNG = 4'd5,
        IFFTX  = 4'd6,
        IFFTY  = 4'd7,
        IFFTZ  = 4'd8,
        FCALC  = 4'd9,
        RSVDSA = 4'd10,
        RSVDSB = 4'd11,
        RSVDSC = 4'd12,
        RSVDSD = 4'd13,
        RSVDSE = 4'd14,
        RSVDSF = 4'd15
    } state_t;

    localparam logic [GM_AW-1:0] CLR_LAST = GM_AW'(GRID_WORDS - 1);

    // The register is kept as a plain vector so that every 4-bit value,
    // including the reserved ones, is representable and recoverable.
    logic [3:0]        state_q;
    state_t            state_d;
    logic [GM_AW-1:0]  clr_cnt_q;
    logic [ITER_W-1:0] iter_q;
    logic              err_q;
    logic              pgmap_start_q;
    logic              fft_start_q;
    logic              fcalc_start_q;
    logic [1:0]        axis_q;
    logic              inv_q;
    logic              green_q;

    logic              first_cycle;
    logic              step_done;
    logic              illegal;
    logic              entering;
    logic [1:0]        axis_d;
    logic              inv_d;
    logic              green_d;

    // A done pulse coinciding with the start pulse cannot belong to the
    // operation just started, so it is ignored.
    assign first_cycle = pgmap_start_q | fft_start_q | fcalc_start_q;

    always_comb begin
        state_d   = state_t'(state_q);
        step_done = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            INIT:   if (clr_cnt_q == CLR_LAST) state_d = WAIT;
            WAIT:   if (part_valid_i) state_d = PGMAP;
            PGMAP:  if (pgmap_done_i && !first_cycle) state_d = FFTX;
            FFTX:   if (fft_done_i && !first_cycle) state_d = FFTY;
            FFTY:   if (fft_done_i && !first_cycle) state_d = FFTZNG;
            FFTZNG: if (fft_done_i && !first_cycle) state_d = IFFTX;
            IFFTX:  if (fft_done_i && !first_cycle) state_d = IFFTY;
            IFFTY:  if (fft_done_i && !first_cycle) state_d = IFFTZ;
            IFFTZ:  if (fft_done_i && !first_cycle) state_d = FCALC;
            FCALC: begin
                if (fcalc_done_i && !first_cycle) begin
                    state_d   = INIT;
                    step_done = 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                illegal = 1'b1;
            end
        endcase
        if (soft_rst_i) begin
            state_d   = INIT;
            step_done = 1'b0;
        end
    end

    // Stage outputs are derived from the next state so they are valid from
    // the first cycle of the stage, together with the start pulse.
    always_comb begin
        axis_d  = 2'd0;
        inv_d   = 1'b0;
        green_d = 1'b0;
        case (state_d)
            FFTY:   axis_d = 2'd1;
            FFTZNG: begin
                axis_d  = 2'd2;
                green_d = 1'b1;
            end
            IFFTX:  inv_d = 1'b1;
            IFFTY: begin
                axis_d = 2'd1;
                inv_d  = 1'b1;
            end
            IFFTZ: begin
                axis_d = 2'd2;
                inv_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign entering = (4'(state_d) != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            clr_cnt_q     <= '0;
            iter_q        <= '0;
            err_q         <= 1'b0;
            pgmap_start_q <= 1'b0;
            fft_start_q   <= 1'b0;
            fcalc_start_q <= 1'b0;
            axis_q        <= 2'd0;
            inv_q         <= 1'b0;
            green_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pgmap_start_q <= entering && (state_d == PGMAP);
            fft_start_q   <= entering && (state_d >= FFTX) && (state_d <= IFFTZ);
            fcalc_start_q <= entering && (state_d == FCALC);
            axis_q        <= axis_d;
            inv_q         <= inv_d;
            green_q       <= green_d;
            if ((state_q == INIT) && (state_d == INIT) && !soft_rst_i)
                clr_cnt_q <= clr_cnt_q + 1'b1;
            else
                clr_cnt_q <= '0;
            if (step_done)
                iter_q <= iter_q + 1'b1;
            if (illegal)
                err_q <= 1'b1;
        end
    end

    // An abort in a start cycle withdraws that start so the unit never sees
    // a request the sequencer has already abandoned.
    assign pgmap_start_o = pgmap_start_q & ~soft_rst_i;
    assign fft_start_o   = fft_start_q & ~soft_rst_i;
    assign fcalc_start_o = fcalc_start_q & ~soft_rst_i;
    assign fft_axis_o    = axis_q;
    assign fft_inv_o     = inv_q;
    assign green_en_o    = green_q;

    // Qualified with rst_n so no clear write is presented while in reset.
    assign gm_clr_we_o   = rst_n && (state_q == INIT);
    assign gm_clr_addr_o = clr_cnt_q;
    assign state_o       = state_q;
    assign busy_o        = (state_q != WAIT);
    assign iter_cnt_o    = iter_q;
    assign err_o         = err_q;

endmodule
